// File: rtl/act_repack_pkg.sv
// Shared widths, FSM state type and status encodings for the activation repacker.
package act_repack_pkg;

    localparam int unsigned ACT_DATA_W  = 4;
    localparam int unsigned ACT_NUM_IMG = 3;
    localparam int unsigned ACT_NEURONS = 16;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [1:0] STATUS_IDLE     = 2'b00;
    localparam logic [1:0] STATUS_FILLING  = 2'b01;
    localparam logic [1:0] STATUS_DRAINING = 2'b10;

endpackage

// File: rtl/act_repacker_buf.sv
// act_buf: NUM_IMG x NEURONS activation register file with one write port
// and one column read port returning {img[NUM_IMG-1], ..., img[0]} for a neuron.
module act_buf #(
    parameter int unsigned  NUM_IMG = 3,
    parameter int unsigned  NEURONS = 16,
    parameter int unsigned  DATA_W  = 4,
    localparam int unsigned IMG_W   = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1,
    localparam int unsigned NRN_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [IMG_W-1:0]          wr_img,
    input  logic [NRN_W-1:0]          wr_nrn,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [NRN_W-1:0]          rd_nrn,
    output logic [NUM_IMG*DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [NUM_IMG][NEURONS];

    // Single write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_img][wr_nrn] <= wr_data;
        end
    end

    // Column read: one neuron across all images, image 0 in the low bits.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(NUM_IMG); i++) begin
            rd_data[i*DATA_W +: DATA_W] = mem[i][rd_nrn];
        end
    end

endmodule

// File: rtl/act_repacker.sv
// act_repacker: buffers one batch of image-major 4-bit activations and
// re-emits it neuron-major as {img2, img1, img0} pixel words.
// Optional feature: define ACT_REPACK_TLAST_EN to add an m_tlast output.
module act_repacker
    import act_repack_pkg::*;
#(
    parameter int unsigned NEURONS = ACT_NEURONS,
    parameter int unsigned NUM_IMG = ACT_NUM_IMG,
    parameter int unsigned DATA_W  = ACT_DATA_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_W-1:0]         s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [NUM_IMG*DATA_W-1:0] m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
`ifdef ACT_REPACK_TLAST_EN
    output logic                      m_tlast,
`endif
    output logic [1:0]                status
);

    localparam int unsigned IMG_W = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;
    localparam int unsigned NRN_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam int unsigned PIX_W = NUM_IMG * DATA_W;

    state_t            state;
    logic [IMG_W-1:0]  w_img;
    logic [NRN_W-1:0]  w_nrn;
    logic [NRN_W-1:0]  r_idx;

    logic              s_fire_c;
    logic              m_fire_c;
    logic              w_last_c;
    logic              r_last_c;
    logic [NRN_W-1:0]  rd_nrn_c;
    logic [PIX_W-1:0]  col_c;
    logic [PIX_W-1:0]  col_fwd_c;

    assign s_fire_c = s_tvalid && s_tready;
    assign m_fire_c = m_tvalid && m_tready;
    assign w_last_c = (w_img == IMG_W'(NUM_IMG - 1)) && (w_nrn == NRN_W'(NEURONS - 1));
    assign r_last_c = (r_idx == NRN_W'(NEURONS - 1));
    // Column to present next: neuron 0 when entering DRAIN, else the following neuron.
    assign rd_nrn_c = (state == ST_FILL) ? '0 : r_idx + NRN_W'(1);

    act_buf #(
        .NUM_IMG (NUM_IMG),
        .NEURONS (NEURONS),
        .DATA_W  (DATA_W)
    ) u_buf (
        .clk     (CLK),
        .we      (s_fire_c),
        .wr_img  (w_img),
        .wr_nrn  (w_nrn),
        .wr_data (s_tdata),
        .rd_nrn  (rd_nrn_c),
        .rd_data (col_c)
    );

    // Forward a same-cycle write into the column being loaded (only matters when NEURONS == 1).
    always_comb begin
        col_fwd_c = col_c;
        if (s_fire_c && (w_nrn == rd_nrn_c)) begin
            col_fwd_c[32'(w_img)*DATA_W +: DATA_W] = s_tdata;
        end
    end

    // FILL/DRAIN control with counters and registered handshake/status outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_FILL;
            w_img    <= '0;
            w_nrn    <= '0;
            r_idx    <= '0;
            s_tready <= 1'b0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            status   <= STATUS_IDLE;
`ifdef ACT_REPACK_TLAST_EN
            m_tlast  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_FILL: begin
                    s_tready <= 1'b1;
                    if (s_fire_c) begin
                        if (w_last_c) begin
                            w_img    <= '0;
                            w_nrn    <= '0;
                            state    <= ST_DRAIN;
                            s_tready <= 1'b0;
                            m_tvalid <= 1'b1;
                            m_tdata  <= col_fwd_c;
                            status   <= STATUS_DRAINING;
`ifdef ACT_REPACK_TLAST_EN
                            m_tlast  <= (NEURONS == 1);
`endif
                        end else begin
                            if (w_nrn == NRN_W'(NEURONS - 1)) begin
                                w_nrn <= '0;
                                w_img <= w_img + IMG_W'(1);
                            end else begin
                                w_nrn <= w_nrn + NRN_W'(1);
                            end
                            status <= STATUS_FILLING;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_fire_c) begin
                        if (r_last_c) begin
                            r_idx    <= '0;
                            state    <= ST_FILL;
                            m_tvalid <= 1'b0;
                            m_tdata  <= '0;
                            s_tready <= 1'b1;
                            status   <= STATUS_IDLE;
`ifdef ACT_REPACK_TLAST_EN
                            m_tlast  <= 1'b0;
`endif
                        end else begin
                            r_idx   <= r_idx + NRN_W'(1);
                            m_tdata <= col_fwd_c;
`ifdef ACT_REPACK_TLAST_EN
                            m_tlast <= ((r_idx + NRN_W'(1)) == NRN_W'(NEURONS - 1));
`endif
                        end
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule
